mem_responder: RTL
==================

# mem_responder

Memory-side responder for the CPU datapath's MAR/MDR memory port. Accepts read and write requests driven by the datapath (address from MAR, write data from MDR, `Read`/`Write` strobes). Services each request after a programmable number of wait states and returns read data on `OUT_MDR` with a `mem_ready` handshake. Sits between the datapath and the word-addressed RAM array; the control unit stalls on `mem_ready`.

## Interface
Parameters:
- `ADDR_WIDTH`, 9: word-address bits; memory depth is 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 32: word width; must equal the bus width.
- `WAIT_STATES`, 2: idle cycles inserted before each access; range 0..15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `MAR`  in  32  request address; bits `[ADDR_WIDTH-1:0]` select the word.
- `MDR`  in  DATA_WIDTH  write data.
- `Read`  in  1  read request level.
- `Write`  in  1  write request level.
- `OUT_MDR`  out  DATA_WIDTH  read data, registered.
- `mem_ready`  out  1  request complete; held while the request stays asserted.
- `mem_busy`  out  1  high in every state except IDLE.
- `addr_err`  out  1  one-cycle pulse for an illegal or out-of-range request.

## Operation
- The FSM has four states: IDLE, WAIT, ACCESS, DONE.
- **IDLE**
  - On an edge with exactly one of `Read`/`Write` high and `MAR[31:ADDR_WIDTH]==0`: latch the address, data and op.
  - Then go to WAIT with `cnt=WAIT_STATES`, or straight to ACCESS when `WAIT_STATES==0`.
- **Illegal requests, detected in IDLE**
  - Cases: `Read` and `Write` both high, or any `MAR[31:ADDR_WIDTH]` bit set.
  - Response: pulse `addr_err` for one cycle, go to DONE without touching memory.
  - For an out-of-range read, `OUT_MDR` is loaded with 0.
- **WAIT**
  - Decrement `cnt` each edge.
  - On the edge where `cnt==1`, go to ACCESS.
- **ACCESS**
  - Perform exactly one array operation on this edge.
    - Read: `OUT_MDR <= mem[addr]`.
    - Write: `mem[addr] <= data`.
  - Go to DONE.
- **DONE**
  - `mem_ready=1`.
  - Stay while `Read|Write` is high; go to IDLE on the first edge where both are low.
  - A held request is never served twice.
- **Data rules**
  - Request inputs are ignored outside IDLE; latched values are used.
  - `OUT_MDR` keeps the last read value until the next read completes. Writes do not change it.
- **Reset values**
  - `OUT_MDR=0`, `mem_ready=0`, `mem_busy=0`, `addr_err=0`, state IDLE, `cnt=0`.
  - Array contents are not cleared by reset.
- **Reset mid-operation**
  - Immediately return to IDLE.
  - A write that has not reached its ACCESS edge never commits.
  - A write already committed is kept.

## Timing
- Count the capture edge in IDLE as edge 1. `mem_ready` rises after edge `WAIT_STATES+2`.
  - Default: 4 edges.
  - `WAIT_STATES==0`: 2 edges.
- `OUT_MDR` is valid in the same cycle `mem_ready` is high.
- The datapath's `MDRin` with `Read` high must be asserted while `mem_ready=1`.
- `addr_err` is high in the cycle after the capture edge; `mem_ready` follows on the next edge.
- **Minimum request spacing:** `WAIT_STATES+3` cycles, i.e. release plus one IDLE edge.
- **Simultaneous events:**
  - A request asserted on the same edge that DONE exits to IDLE is not captured; it is captured on the following edge.
  - Read-after-write to the same address returns the new data.

## Structure
- Package `mem_pkg`:
  - state enum `mem_state_t {IDLE, WAIT, ACCESS, DONE}`;
  - `MEM_ADDR_WIDTH=9`, `MEM_DATA_WIDTH=32`;
  - `MEM_WAIT_MAX=15`.
- Sub-module `sram_array`:
  - single-port synchronous RAM with write enable, read enable and registered read;
  - optional `$readmemh` init file parameter.
- The FSM, wait counter and error logic live in `mem_responder`.

## Test plan
- **Reset:** reset low mid-WAIT → all outputs 0 and state IDLE; no write committed.
- **Write then read** (`WAIT_STATES=2`):
  - `Write` with `MAR=0x05`, `MDR=0xDEADBEEF` → `mem_ready` after edge 4.
  - `Read` with `MAR=0x05` → `OUT_MDR=0xDEADBEEF` after edge 4.
- **Held request:** `Read` high for 10 cycles at `MAR=0x10` → exactly one access; `mem_ready` stays high until `Read` drops, then `mem_busy=0` on the next edge.
- **Illegal requests:**
  - `MAR=0x00000200`, `Read` → `addr_err` one-cycle pulse, `OUT_MDR=0`, no array access.
  - `Read` and `Write` both high → `addr_err` pulse, memory unchanged.
- **Zero wait states** (`WAIT_STATES=0`): read of `mem[0x1FF]=0x12345678` → `mem_ready` after edge 2 with correct data.
- **Back-to-back:**
  - Write `0x1` to addr 3.
  - Release, then read addr 3 on the next allowed edge → `0x1`.
  - `OUT_MDR` is unchanged by the intervening write.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and limits for the MAR/MDR memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

    localparam int MEM_ADDR_WIDTH = 9;
    localparam int MEM_DATA_WIDTH = 32;
    localparam int MEM_WAIT_MAX   = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } mem_state_t;

    // Wait-state loads outside 0..MEM_WAIT_MAX saturate rather than wrap.
    function automatic logic [3:0] clamp_wait(input int ws);
        if (ws > MEM_WAIT_MAX) return 4'(MEM_WAIT_MAX);
        if (ws < 0)            return 4'd0;
        return 4'(ws);
    endfunction

endpackage

// File: rtl/mem_responder_sram_array.sv
// Single-port word RAM with write enable, read enable and a registered read port.
// Latency: read data appears one edge after re; writes land on the we edge.
// Backpressure: none; one operation per enabled edge.
module sram_array #(
    parameter int    ADDR_WIDTH = 9,
    parameter int    DATA_WIDTH = 32,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Array contents deliberately survive reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures one Read/Write request, waits WAIT_STATES, accesses the RAM once.
// Latency: mem_ready rises WAIT_STATES+2 edges after the capture edge (2 edges for illegal requests).
// Backpressure: requests are only sampled in IDLE; the requester holds its strobe until mem_ready.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH  = MEM_DATA_WIDTH,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           MAR,
    input  logic [DATA_WIDTH-1:0] MDR,
    input  logic                  Read,
    input  logic                  Write,
    output logic [DATA_WIDTH-1:0] OUT_MDR,
    output logic                  mem_ready,
    output logic                  mem_busy,
    output logic                  addr_err
);

    localparam logic [3:0] WS_LOAD = clamp_wait(WAIT_STATES);

    mem_state_t            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;
    logic                  addr_err_q, addr_err_d;
    logic                  zero_q, zero_d;

    logic                  out_of_range;
    logic                  legal_req;
    logic                  ram_we;
    logic                  ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign out_of_range = |MAR[31:ADDR_WIDTH];
    assign legal_req    = (Read ^ Write) && !out_of_range;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_d       = wr_q;
        err_d      = err_q;
        addr_err_d = 1'b0;
        zero_d     = zero_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        case (state_q)
            IDLE: begin
                if (Read || Write) begin
                    if (legal_req) begin
                        addr_d = MAR[ADDR_WIDTH-1:0];
                        data_d = MDR;
                        wr_d   = Write;
                        err_d  = 1'b0;
                        if (WS_LOAD == 4'd0) begin
                            state_d = ACCESS;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = WS_LOAD;
                        end
                    end else begin
                        // Illegal requests pass through ACCESS with the array gated off,
                        // so addr_err leads mem_ready by exactly one cycle.
                        err_d      = 1'b1;
                        addr_err_d = 1'b1;
                        state_d    = ACCESS;
                        if (Read && out_of_range) begin
                            zero_d = 1'b1;
                        end
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!err_q) begin
                    ram_we = wr_q;
                    ram_re = !wr_q;
                    if (!wr_q) begin
                        zero_d = 1'b0;
                    end
                end
                state_d = DONE;
            end
            DONE: begin
                if (!(Read || Write)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_err_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
            addr_err_q <= addr_err_d;
            zero_q     <= zero_d;
        end
    end

    sram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .INIT_FILE  ("")
    ) u_sram (
        .clk   (clk),
        .rst_n (reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

    // The RAM read register holds the last real read; zero_q masks it after an out-of-range read.
    assign OUT_MDR   = zero_q ? '0 : ram_rdata;
    assign mem_ready = (state_q == DONE);
    assign mem_busy  = (state_q != IDLE);
    assign addr_err  = addr_err_q;

endmodule
